sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter WIDTH, default 8, maximum pattern length in bits.
REQ-002 Parameter LEN_W, default 4, width of LEN; SHALL satisfy 2**LEN_W > WIDTH.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RST_N  input  1  reset; asynchronous, active-low.
REQ-005 START  input  1  request one transmission job; sampled only in IDLE.
REQ-006 ABORT  input  1  synchronous cancel of the current job.
REQ-007 PATTERN  input  WIDTH  bit pattern to send; captured at job start.
REQ-008 LEN  input  LEN_W  number of pattern bits to send; captured at job start.
REQ-009 REPEAT  input  4  extra passes; total passes = REPEAT+1; captured at job start.
REQ-010 OUT  output  1  serial data bit, registered.
REQ-011 VALID  output  1  OUT carries a pattern bit this cycle, registered.
REQ-012 BUSY  output  1  job in progress (any state other than IDLE), registered.
REQ-013 DONE  output  1  one-cycle completion pulse, registered.

Function
REQ-014 States SHALL be IDLE, SHIFT, GAP and FINISH; all outputs SHALL be Moore (decoded from registered state and datapath only).
REQ-015 In IDLE with START=1 at a rising edge, PATTERN, LEN and REPEAT SHALL be captured and state SHALL go to SHIFT.
REQ-016 Effective length L SHALL be LEN when 1<=LEN<=WIDTH, otherwise WIDTH (LEN=0 or LEN>WIDTH -> WIDTH).
REQ-017 In SHIFT, OUT SHALL present captured PATTERN bits L-1 down to 0 (MSB of the L-bit field first), one bit per cycle, with VALID=1.
REQ-018 The first bit SHALL appear in the cycle immediately after the START-sampling edge (latency 1).
REQ-019 After bit 0 of a pass, if passes remain, state SHALL go to GAP for exactly one cycle (VALID=0, OUT=0) and then return to SHIFT at bit L-1.
REQ-020 After bit 0 of the final pass, state SHALL go to FINISH for one cycle with DONE=1, BUSY=1, VALID=0, then go to IDLE.
REQ-021 Job duration from the START edge to the DONE cycle inclusive SHALL be (REPEAT+1)*L + REPEAT + 1 cycles.
REQ-022 START SHALL be ignored in SHIFT, GAP and FINISH; captured values SHALL NOT change mid-job.
REQ-023 ABORT=1 at an edge in SHIFT or GAP SHALL force IDLE next cycle with VALID=0, OUT=0, BUSY=0 and no DONE pulse.
REQ-024 ABORT in FINISH SHALL NOT suppress DONE; ABORT in IDLE SHALL have no effect.
REQ-025 ABORT and START both high in IDLE: ABORT SHALL win and no job SHALL start.
REQ-026 In IDLE, OUT=0, VALID=0, BUSY=0 and DONE=0.
REQ-027 The bit counter SHALL not wrap: it SHALL reload L-1 on each pass and never index beyond WIDTH-1.
REQ-028 When OUT is fed to the "101" sequence detector on the same CLK, a pattern of 3'b101 with L=3 SHALL cause that detector to assert DET.

Reset
REQ-029 RST_N=0 SHALL, asynchronously and regardless of CLK, force IDLE, OUT=0, VALID=0, BUSY=0, DONE=0, and clear the pass and bit counters.
REQ-030 Reset asserted mid-job SHALL discard the job with no DONE pulse; after RST_N deasserts, the first START SHALL begin a fresh job.
REQ-031 Captured PATTERN/LEN/REPEAT registers need not be reset, but SHALL NOT affect any output while in IDLE.

Verification
REQ-032 PATTERN=8'h05, LEN=3, REPEAT=0, START at edge 0 -> cycles 1-3 OUT=1,0,1 with VALID=1; cycle 4 DONE=1; cycle 5 BUSY=0.
REQ-033 PATTERN=8'h05, LEN=3, REPEAT=2 -> OUT sequence 101,gap,101,gap,101 (VALID low in gaps); DONE in cycle 12 (REQ-021: 3*3+2+1=12).
REQ-034 PATTERN=8'hA5, LEN=0 -> 8 bits 1,0,1,0,0,1,0,1, then DONE; LEN=9 -> same result.
REQ-035 ABORT on the 2nd bit of PATTERN=8'hFF, LEN=8 -> next cycle IDLE, VALID=0, BUSY=0, no DONE; START held high through a job -> exactly one job runs.
REQ-036 RST_N pulsed low mid-SHIFT, between clock edges -> outputs are 0 immediately without waiting for CLK; the next START replays the pattern from its first bit.
REQ-037 Loopback into the "101" detector with PATTERN=8'h05, LEN=3 -> DET=1 exactly one cycle after the third bit.

Source files
------------

// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
//
// Serialises the low L bits of a captured pattern, MSB of the L-bit field
// first, for REPEAT+1 passes separated by a one-cycle gap, then pulses DONE.
// L is LEN when 1 <= LEN <= WIDTH, otherwise WIDTH.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request a job (sampled only in IDLE)
//   abort       in   synchronous cancel of the running job (SHIFT/GAP only)
//   pattern     in   [WIDTH-1:0] bits to send, captured at job start
//   len         in   [LEN_W-1:0] number of bits per pass, captured at job start
//   repeat_cnt  in   [3:0] extra passes (total passes = repeat_cnt+1)
//   out         out  serial data bit (registered)
//   valid       out  out carries a pattern bit (registered)
//   busy        out  job in progress, any state but IDLE (registered)
//   done        out  one-cycle completion pulse (registered)
//   state_dbg   out  [1:0] current FSM state for observation
//
// Handshake: start is a level request; a job begins on the first rising edge
// where the FSM is IDLE, start=1 and abort=0. valid qualifies out one bit per
// cycle with no backpressure; done marks the cycle after the last bit.
//
// seq_detector_101
//
// Registered "101" detector on a serial stream; det rises in the cycle after
// the final '1' of the sequence was presented on din.
//
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   din    in   serial data bit
//   det    out  registered detect flag
// -----------------------------------------------------------------------------

module sequence_generator #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       repeat_cnt,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;     // effective length L of the job
  logic [3:0]       pass_q, pass_d;   // passes still to run after this one
  logic [LEN_W-1:0] bit_q, bit_d;     // index of the bit being presented
  logic [LEN_W-1:0] len_eff;
  logic [WIDTH-1:0] bit_mask;
  logic             out_d, valid_d, busy_d, done_d;

  // Out-of-range lengths (0 or above WIDTH) fall back to the full width so
  // the bit index can never point outside the pattern.
  always_comb begin
    len_eff = WIDTH_L;
    if ((len != '0) && (len <= WIDTH_L)) begin
      len_eff = len;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    pass_d  = pass_q;
    bit_d   = bit_q;

    case (state_q)
      IDLE: begin
        // abort has priority over start: a simultaneous pair starts nothing.
        if (start && !abort) begin
          pat_d   = pattern;
          len_d   = len_eff;
          pass_d  = repeat_cnt;
          bit_d   = len_eff - ONE_L;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = '0;
          bit_d   = '0;
        end else if (bit_q == '0) begin
          if (pass_q != 4'd0) begin
            pass_d  = pass_q - 4'd1;
            state_d = GAP;
          end else begin
            state_d = FINISH;
          end
        end else begin
          bit_d = bit_q - ONE_L;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = '0;
          bit_d   = '0;
        end else begin
          // Each pass reloads from the top of the field; no wrap-around.
          bit_d   = len_q - ONE_L;
          state_d = SHIFT;
        end
      end

      FINISH: begin
        // abort is deliberately ignored here; the DONE pulse is already out.
        state_d = IDLE;
        pass_d  = '0;
        bit_d   = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // every output is a pure flop output aligned with its state.
  always_comb begin
    bit_mask = WIDTH'(1) << bit_d;
    valid_d  = (state_d == SHIFT);
    out_d    = valid_d && ((pat_d & bit_mask) != '0);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      bit_q   <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      bit_q   <= bit_d;
      out     <= out_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign state_dbg = state_q;

endmodule

module seq_detector_101 (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic det
);

  // hist[1] is the older of the two previous bits, hist[0] the newer.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b00;
      det  <= 1'b0;
    end else begin
      hist <= {hist[0], din};
      det  <= (hist == 2'b10) && din;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] repeat_cnt;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;
  logic       det;

  // Expected stream tokens: 0/1 = data bit, 2 = gap cycle, 3 = done cycle.
  logic [1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  sequence_generator #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .repeat_cnt(repeat_cnt),
    .out(out), .valid(valid), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  seq_detector_101 u_det (.clk(clk), .rst_n(rst_n), .din(out), .det(det));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endfunction

  // '0'/'1' data bit, 'g' gap, 'd' done.
  function automatic void push_str(string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "0": exp_q.push_back(2'd0);
        "1": exp_q.push_back(2'd1);
        "g": exp_q.push_back(2'd2);
        default: exp_q.push_back(2'd3);
      endcase
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [1:0] obs;
    logic [1:0] tok;
    if (rst_n) begin
      if (busy) begin
        obs = valid ? {1'b0, out} : (done ? 2'd3 : 2'd2);
        if (!valid) check("out_low_without_valid", out, 0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_busy_cycle: token=%0d, expected none", obs);
        end else begin
          tok = exp_q.pop_front();
          check("stream_token", obs, tok);
        end
      end else begin
        check("idle_outputs", {state_dbg, out, valid, done}, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_job(input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input string expect_str,
                         input int exp_cyc, input bit hold);
    int cyc;
    push_str(expect_str);
    @(posedge clk); #1;
    pattern = p; len = l; repeat_cnt = r; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    // Scramble inputs to prove they were captured at job start.
    pattern = ~p; len = l + 4'd1; repeat_cnt = r + 4'd1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 100);
    check("job_cycles_to_done", cyc, exp_cyc);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic abort_job(input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] r, input string expect_str,
                           input int abort_cycle);
    push_str(expect_str);
    @(posedge clk); #1;
    pattern = p; len = l; repeat_cnt = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (abort_cycle - 1) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid_out", {valid, out}, 0);
    check("abort_state", state_dbg, 0);
    repeat (3) @(negedge clk);
    check("abort_scoreboard_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] det_exp;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; repeat_cnt = '0;
    #3;
    check("reset_outputs", {state_dbg, busy, out, valid, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_job(8'h05, 4'd3,  4'd0, "101d", 4, 1'b0);
    run_job(8'h05, 4'd3,  4'd2, "101g101g101d", 12, 1'b0);
    run_job(8'hA5, 4'd0,  4'd0, "10100101d", 9, 1'b0);
    run_job(8'hA5, 4'd9,  4'd0, "10100101d", 9, 1'b0);
    run_job(8'h80, 4'd15, 4'd0, "10000000d", 9, 1'b0);
    run_job(8'h3C, 4'd5,  4'd1, "11100g11100d", 12, 1'b0);
    run_job(8'h01, 4'd1,  4'd3, "1g1g1g1d", 8, 1'b0);

    // start held high for the whole job: exactly one job must run.
    run_job(8'h06, 4'd3, 4'd0, "110d", 4, 1'b1);

    // Abort on the second bit, then abort during a gap.
    abort_job(8'hFF, 4'd8, 4'd0, "11", 2);
    abort_job(8'h02, 4'd2, 4'd1, "10g", 3);

    // abort and start together in IDLE: nothing starts.
    @(posedge clk); #1;
    pattern = 8'hFF; len = 4'd8; repeat_cnt = 4'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle_busy", busy, 0);
    check("abort_start_idle_state", state_dbg, 0);
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of a SHIFT cycle.
    push_str("10");
    @(posedge clk); #1;
    pattern = 8'hA5; len = 4'd8; repeat_cnt = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("pre_reset_valid_out", {valid, out}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {state_dbg, busy, out, valid, done}, 0);
    check("reset_scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_job(8'hA5, 4'd8, 4'd0, "10100101d", 9, 1'b0);

    // Loopback into the 101 detector: det only in cycle 4.
    det_exp = 6'b001000;
    push_str("101d");
    @(posedge clk); #1;
    pattern = 8'h05; len = 4'd3; repeat_cnt = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("det_loopback", det, det_exp[c-1]);
    end
    check("loopback_scoreboard_drained", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
